s2_controle_param: RTL and testbench

Parametrised control unit with integrated counters for the memory/sequence game. It plays round r as r+1 sequence elements with programmable show/gap times, then waits for the player's answers under a programmable timeout. Unlike the previous generation, it grants MAX_ERR lives before ending the game and computes the final score internally. It sits between the sequence ROM/comparator datapath and the LED/display drivers.

---
 rtl/s2_controle_param.sv | 228 ++++++++++++++++++++++
 tb/tb_s2_controle_param.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/s2_controle_param.sv
// Control unit for the memory/sequence game: shows round r as r+1 timed elements,
// then collects the player's answers with a per-answer timeout, lives and a score.
module s2_controle_param #(
    parameter int N_ROUNDS = 16,
    parameter int ADDR_W   = 4,
    parameter int T_SHOW   = 1000,
    parameter int T_GAP    = 500,
    parameter int T_PLAY   = 5000,
    parameter int MAX_ERR  = 3,
    parameter int PENALTY  = 10
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              jogar,
    input  logic              treinamento,
    input  logic              jogada,
    input  logic              acerto,
    output logic [ADDR_W-1:0] endereco,
    output logic [ADDR_W-1:0] limite,
    output logic [3:0]        erros,
    output logic [6:0]        pontos,
    output logic              registraR,
    output logic              mostraJ,
    output logic              mostraB,
    output logic              serrou,
    output logic              pronto,
    output logic              acertou,
    output logic              db_timeout,
    output logic [3:0]        db_estado
);

    localparam int T_MAX = (T_SHOW > T_GAP) ? ((T_SHOW > T_PLAY) ? T_SHOW : T_PLAY)
                                            : ((T_GAP > T_PLAY) ? T_GAP : T_PLAY);
    localparam int TMR_W = $clog2(T_MAX);

    localparam logic [TMR_W-1:0]  SHOW_LAST  = TMR_W'(T_SHOW - 1);
    localparam logic [TMR_W-1:0]  GAP_LAST   = TMR_W'(T_GAP - 1);
    localparam logic [TMR_W-1:0]  PLAY_LAST  = TMR_W'(T_PLAY - 1);
    localparam logic [ADDR_W-1:0] ROUND_LAST = ADDR_W'(N_ROUNDS - 1);

    typedef enum logic [3:0] {
        INICIAL     = 4'h0,
        PREPARACAO  = 4'h1,
        MOSTRA      = 4'h2,
        PAUSA       = 4'h3,
        ESPERA      = 4'h4,
        REGISTRA    = 4'h5,
        COMPARA     = 4'h6,
        PROXIMO     = 4'h7,
        FIM_RODADA  = 4'h8,
        ERROU       = 4'h9,
        FIM_ACERTOU = 4'hA,
        FIM_TIMEOUT = 4'hB,
        FIM_ERROS   = 4'hC,
        TREINO      = 4'hD
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] endereco_q, endereco_d;
    logic [ADDR_W-1:0] limite_q, limite_d;
    logic [3:0]        erros_q, erros_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic              registra_r_q, registra_r_d;
    logic              mostra_j_q, mostra_j_d;
    logic              mostra_b_q, mostra_b_d;
    logic              serrou_q, serrou_d;
    logic              pronto_q, pronto_d;
    logic              acertou_q, acertou_d;
    logic              timeout_q, timeout_d;
    int                penalty_total;

    always_comb begin
        // NOTE: every signal gets a hold value first so no path through the case infers a latch.
        state_d    = state_q;
        endereco_d = endereco_q;
        limite_d   = limite_q;
        erros_d    = erros_q;
        timer_d    = timer_q;

        case (state_q)
            INICIAL: if (jogar) state_d = PREPARACAO;
            PREPARACAO: begin
                endereco_d = '0;
                limite_d   = '0;
                erros_d    = '0;
                timer_d    = '0;
                state_d    = treinamento ? TREINO : MOSTRA;
            end
            TREINO: if (!treinamento) state_d = PREPARACAO;
            MOSTRA: begin
                if (timer_q == SHOW_LAST) begin
                    timer_d = '0;
                    state_d = PAUSA;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            PAUSA: begin
                if (timer_q == GAP_LAST) begin
                    timer_d = '0;
                    if (endereco_q == limite_q) begin
                        endereco_d = '0;
                        state_d    = ESPERA;
                    end else begin
                        endereco_d = endereco_q + ADDR_W'(1);
                        state_d    = MOSTRA;
                    end
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            ESPERA: begin
                // A press on the last allowed cycle still counts as an answer.
                if (jogada) begin
                    timer_d = '0;
                    state_d = REGISTRA;
                end else if (timer_q == PLAY_LAST) begin
                    state_d = FIM_TIMEOUT;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            REGISTRA: state_d = COMPARA;
            COMPARA: begin
                if (!acerto) begin
                    state_d = ERROU;
                end else if (endereco_q == limite_q) begin
                    timer_d = '0;
                    state_d = FIM_RODADA;
                end else begin
                    state_d = PROXIMO;
                end
            end
            PROXIMO: begin
                endereco_d = endereco_q + ADDR_W'(1);
                timer_d    = '0;
                state_d    = ESPERA;
            end
            FIM_RODADA: begin
                if (timer_q == GAP_LAST) begin
                    timer_d = '0;
                    if (limite_q == ROUND_LAST) begin
                        state_d = FIM_ACERTOU;
                    end else begin
                        limite_d   = limite_q + ADDR_W'(1);
                        endereco_d = '0;
                        state_d    = MOSTRA;
                    end
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            ERROU: begin
                if (erros_q != 4'hF) erros_d = erros_q + 4'd1;
                if (({1'b0, erros_q} + 5'd1) >= 5'(MAX_ERR)) begin
                    state_d = FIM_ERROS;
                end else begin
                    endereco_d = '0;
                    timer_d    = '0;
                    state_d    = MOSTRA;
                end
            end
            FIM_ACERTOU, FIM_TIMEOUT, FIM_ERROS: if (jogar) state_d = PREPARACAO;
            default: state_d = INICIAL;
        endcase

        // Flags are decoded from the next state so the registered copy lines up with state_q.
        registra_r_d = (state_d == REGISTRA);
        mostra_j_d   = (state_d == MOSTRA);
        mostra_b_d   = (state_d == ESPERA) || (state_d == COMPARA) ||
                       (state_d == FIM_RODADA) || (state_d == TREINO);
        serrou_d     = (state_d == ERROU) || (state_d == FIM_ERROS);
        pronto_d     = (state_d == FIM_ACERTOU) || (state_d == FIM_TIMEOUT) ||
                       (state_d == FIM_ERROS);
        acertou_d    = (state_d == FIM_ACERTOU);
        timeout_d    = (state_d == FIM_TIMEOUT);
    end

    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!reset) begin
            state_q      <= INICIAL;
            endereco_q   <= '0;
            limite_q     <= '0;
            erros_q      <= '0;
            timer_q      <= '0;
            registra_r_q <= 1'b0;
            mostra_j_q   <= 1'b0;
            mostra_b_q   <= 1'b0;
            serrou_q     <= 1'b0;
            pronto_q     <= 1'b0;
            acertou_q    <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            endereco_q   <= endereco_d;
            limite_q     <= limite_d;
            erros_q      <= erros_d;
            timer_q      <= timer_d;
            registra_r_q <= registra_r_d;
            mostra_j_q   <= mostra_j_d;
            mostra_b_q   <= mostra_b_d;
            serrou_q     <= serrou_d;
            pronto_q     <= pronto_d;
            acertou_q    <= acertou_d;
            timeout_q    <= timeout_d;
        end
    end

    // Score floors at zero instead of wrapping when penalties exceed 100.
    always_comb begin
        penalty_total = PENALTY * int'(erros_q);
        pontos        = (penalty_total >= 100) ? 7'd0 : 7'(100 - penalty_total);
    end

    assign endereco   = endereco_q;
    assign limite     = limite_q;
    assign erros      = erros_q;
    assign registraR  = registra_r_q;
    assign mostraJ    = mostra_j_q;
    assign mostraB    = mostra_b_q;
    assign serrou     = serrou_q;
    assign pronto     = pronto_q;
    assign acertou    = acertou_q;
    assign db_timeout = timeout_q;
    assign db_estado  = state_q;

endmodule

// File: tb/tb_s2_controle_param.sv
// Scoreboard bench for s2_controle_param: the stimulus queues the expected state-entry
// trace (state, outputs, cycles spent in the previous state); a monitor pops and compares.
module tb_s2_controle_param;

    localparam int N_ROUNDS = 3;
    localparam int ADDR_W   = 2;
    localparam int T_SHOW   = 4;
    localparam int T_GAP    = 2;
    localparam int T_PLAY   = 16;
    localparam int MAX_ERR  = 2;
    localparam int PENALTY  = 30;

    localparam logic [3:0] S_INI = 4'h0, S_PREP = 4'h1, S_MOSTRA = 4'h2, S_PAUSA = 4'h3,
                           S_ESPERA = 4'h4, S_REG = 4'h5, S_COMP = 4'h6, S_PROX = 4'h7,
                           S_FRod = 4'h8, S_ERROU = 4'h9, S_FACE = 4'hA, S_FTO = 4'hB,
                           S_FERR = 4'hC, S_TREINO = 4'hD;

    logic              clock, reset, jogar, treinamento, jogada, acerto;
    logic [ADDR_W-1:0] endereco, limite;
    logic [3:0]        erros;
    logic [6:0]        pontos;
    logic              registraR, mostraJ, mostraB, serrou, pronto, acertou, db_timeout;
    logic [3:0]        db_estado;

    s2_controle_param #(
        .N_ROUNDS(N_ROUNDS), .ADDR_W(ADDR_W), .T_SHOW(T_SHOW), .T_GAP(T_GAP),
        .T_PLAY(T_PLAY), .MAX_ERR(MAX_ERR), .PENALTY(PENALTY)
    ) dut (
        .clock(clock), .reset(reset), .jogar(jogar), .treinamento(treinamento),
        .jogada(jogada), .acerto(acerto), .endereco(endereco), .limite(limite),
        .erros(erros), .pontos(pontos), .registraR(registraR), .mostraJ(mostraJ),
        .mostraB(mostraB), .serrou(serrou), .pronto(pronto), .acertou(acertou),
        .db_timeout(db_timeout), .db_estado(db_estado)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [3:0] st;
        int         dwell;   // cycles spent in the previous state; -1 = bench-paced, not checked
        logic [1:0] ende;
        logic [1:0] lim;
        logic [3:0] err;
        logic [6:0] pts;
    } txn_t;

    txn_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Score table for PENALTY=30: 100, 70, 40, 10, then floored at 0.
    function automatic logic [6:0] pts_of(input int err);
        case (err)
            0:       return 7'd100;
            1:       return 7'd70;
            2:       return 7'd40;
            3:       return 7'd10;
            default: return 7'd0;
        endcase
    endfunction

    // {registraR, mostraJ, mostraB, serrou, pronto, acertou, db_timeout}
    function automatic logic [6:0] flags_of(input logic [3:0] st);
        case (st)
            S_REG:                               return 7'b1000000;
            S_MOSTRA:                            return 7'b0100000;
            S_ESPERA, S_COMP, S_FRod, S_TREINO:  return 7'b0010000;
            S_ERROU:                             return 7'b0001000;
            S_FACE:                              return 7'b0000110;
            S_FTO:                               return 7'b0000101;
            S_FERR:                              return 7'b0001100;
            default:                             return 7'b0000000;
        endcase
    endfunction

    task automatic push(input logic [3:0] st, input int dwell, input int ende,
                        input int lim, input int err);
        txn_t t;
        t.st    = st;
        t.dwell = dwell;
        t.ende  = 2'(ende);
        t.lim   = 2'(lim);
        t.err   = 4'(err);
        t.pts   = pts_of(err);
        exp_q.push_back(t);
    endtask

    // Display of round r: r+1 MOSTRA/PAUSA pairs, then ESPERA with endereco back at 0.
    task automatic push_display(input int r, input int err, input int first_dwell);
        for (int e = 0; e <= r; e++) begin
            push(S_MOSTRA, (e == 0) ? first_dwell : T_GAP, e, r, err);
            push(S_PAUSA, T_SHOW, e, r, err);
        end
        push(S_ESPERA, T_GAP, 0, r, err);
    endtask

    // Answers of round r, each pressed on the first ESPERA cycle; bad = index of the wrong one (-1: none).
    task automatic push_answers(input int r, input int err, input int bad);
        for (int e = 0; e <= r; e++) begin
            push(S_REG, 1, e, r, err);
            push(S_COMP, 1, e, r, err);
            if (e == bad) begin
                push(S_ERROU, 1, e, r, err);
                return;
            end
            if (e < r) begin
                push(S_PROX, 1, e, r, err);
                push(S_ESPERA, 1, e + 1, r, err);
            end else begin
                push(S_FRod, 1, e, r, err);
            end
        end
    endtask

    // Monitor: every state entry is a transaction checked against the head of the queue.
    logic [3:0] prev_st = 4'hF;
    int         dwell   = 0;
    txn_t       cur;
    always @(negedge clock) begin
        if (db_estado !== prev_st) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_entry: actual=%0h required=none (from %0h)", db_estado, prev_st);
            end else begin
                cur = exp_q.pop_front();
                check($sformatf("entry_%0h_outputs", cur.st),
                      {6'd0, db_estado, endereco, limite, erros, pontos,
                       registraR, mostraJ, mostraB, serrou, pronto, acertou, db_timeout},
                      {6'd0, cur.st, cur.ende, cur.lim, cur.err, cur.pts, flags_of(cur.st)});
                if (cur.dwell >= 0)
                    check($sformatf("cycles_before_%0h", cur.st), dwell, cur.dwell);
            end
            prev_st = db_estado;
            dwell   = 1;
        end else begin
            dwell++;
        end
    end

    task automatic wait_state(input logic [3:0] s);
        for (int k = 0; k < 300; k++) begin
            @(negedge clock);
            if (db_estado == s) return;
        end
        n_checks++;
        n_fail++;
        $display("FAIL wait_state: actual=%0h required=%0h within 300 cycles", db_estado, s);
    endtask

    task automatic pulse_jogar();
        jogar = 1'b1;
        @(negedge clock);
        jogar = 1'b0;
    endtask

    task automatic answer(input logic ok);
        wait_state(S_ESPERA);
        acerto = ok;
        jogada = 1'b1;
        @(negedge clock);
        jogada = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset = 1'b0; jogar = 1'b0; treinamento = 1'b0; jogada = 1'b0; acerto = 1'b0;
        push(S_INI, -1, 0, 0, 0);
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);

        // Perfect game, with a stray press during MOSTRA that must be ignored.
        push(S_PREP, -1, 0, 0, 0);
        push_display(0, 0, 1); push_answers(0, 0, -1);
        push_display(1, 0, T_GAP); push_answers(1, 0, -1);
        push_display(2, 0, T_GAP); push_answers(2, 0, -1);
        push(S_FACE, T_GAP, 2, 2, 0);
        pulse_jogar();
        wait_state(S_MOSTRA);
        jogada = 1'b1;
        @(negedge clock);
        jogada = 1'b0;
        answer(1'b1);
        repeat (2) answer(1'b1);
        repeat (3) answer(1'b1);
        wait_state(S_FACE);

        // One error on the second element of round 1: round replayed, game still won.
        push(S_PREP, -1, 2, 2, 0);
        push_display(0, 0, 1); push_answers(0, 0, -1);
        push_display(1, 0, T_GAP); push_answers(1, 0, 1);
        push_display(1, 1, 1); push_answers(1, 1, -1);
        push_display(2, 1, T_GAP); push_answers(2, 1, -1);
        push(S_FACE, T_GAP, 2, 2, 1);
        pulse_jogar();
        answer(1'b1);
        answer(1'b1); answer(1'b0);
        answer(1'b1); answer(1'b1);
        repeat (3) answer(1'b1);
        wait_state(S_FACE);

        // Two errors end the game.
        push(S_PREP, -1, 2, 2, 1);
        push_display(0, 0, 1); push_answers(0, 0, 0);
        push_display(0, 1, 1); push_answers(0, 1, 0);
        push(S_FERR, 1, 0, 0, 2);
        pulse_jogar();
        answer(1'b0);
        answer(1'b0);
        wait_state(S_FERR);

        // Restart clears errors; then no press at all -> timeout after T_PLAY cycles.
        push(S_PREP, -1, 0, 0, 2);
        push_display(0, 0, 1);
        push(S_FTO, T_PLAY, 0, 0, 0);
        pulse_jogar();
        wait_state(S_FTO);

        // Press on the last allowed cycle wins over the timeout; round 1 then times out.
        push(S_PREP, -1, 0, 0, 0);
        push_display(0, 0, 1);
        push(S_REG, T_PLAY, 0, 0, 0);
        push(S_COMP, 1, 0, 0, 0);
        push(S_FRod, 1, 0, 0, 0);
        push_display(1, 0, T_GAP);
        push(S_FTO, T_PLAY, 0, 1, 0);
        pulse_jogar();
        wait_state(S_ESPERA);
        repeat (T_PLAY - 1) @(negedge clock);
        acerto = 1'b1;
        jogada = 1'b1;
        @(negedge clock);
        jogada = 1'b0;
        wait_state(S_FTO);

        // Training mode, then a normal game aborted by reset during round 2 display.
        push(S_PREP, -1, 0, 1, 0);
        push(S_TREINO, 1, 0, 0, 0);
        push(S_PREP, -1, 0, 0, 0);
        push_display(0, 0, 1); push_answers(0, 0, -1);
        push_display(1, 0, T_GAP); push_answers(1, 0, -1);
        push(S_MOSTRA, T_GAP, 0, 2, 0);
        push(S_INI, 1, 0, 0, 0);
        treinamento = 1'b1;
        pulse_jogar();
        wait_state(S_TREINO);
        repeat (3) @(negedge clock);
        treinamento = 1'b0;
        answer(1'b1);
        repeat (2) answer(1'b1);
        wait_state(S_MOSTRA);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;

        repeat (5) @(negedge clock);
        check("expected_queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
